// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// | Module   : sram_port_arbiter_if                                          |
// | Purpose  : Bundles the CPU fetch port, the CPU data port and the single  |
// |            SRAM macro port that sram_port_arbiter sits between.          |
// | Modports : slave  - the arbiter (takes requests, drives grants, SRAM     |
// |                     controls and read responses).                        |
// |            master - the environment: CPU fetch/data ports plus the SRAM  |
// |                     macro, which supplies sram_dout.                     |
// | Signals  : if_req/if_addr                   fetch read request           |
// |            if_gnt/if_rvalid/if_rdata        fetch grant and response     |
// |            dm_req/dm_we/dm_bweb/dm_addr/    data request                 |
// |            dm_wdata                                                      |
// |            dm_gnt/dm_rvalid/dm_rdata        data grant and response      |
// |            sram_ceb/sram_web/sram_bweb/     SRAM controls (active-low)   |
// |            sram_addr/sram_din               and address/write data       |
// |            sram_dout                        SRAM read data, 1-cycle late |
// |            cpu_stall                        some request refused         |
// | Revision : 1.0  initial release                                          |
// ============================================================================
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Data port
  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_bweb;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  // SRAM macro port
  logic              sram_ceb;
  logic              sram_web;
  logic [DATA_W-1:0] sram_bweb;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;

  logic              cpu_stall;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_bweb, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output sram_ceb, sram_web, sram_bweb, sram_addr, sram_din,
    input  sram_dout,
    output cpu_stall
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_bweb, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  sram_ceb, sram_web, sram_bweb, sram_addr, sram_din,
    output sram_dout,
    input  cpu_stall
  );
endinterface : sram_port_arbiter_if
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// | Module   : sram_port_arbiter                                             |
// | Purpose  : Shares one single-port SRAM macro between the CPU fetch (IF)  |
// |            and data (DM) ports. At most one access is granted per cycle; |
// |            read data returns to the owning port one cycle after grant.   |
// |            cpu_stall is raised while any request is being refused.       |
// | Ports    : clk    - system clock, rising edge                            |
// |            rst_n  - asynchronous, active-low reset                       |
// |            bus    - sram_port_arbiter_if.slave (CPU ports + SRAM port)   |
// | Params   : ADDR_W       word address width                               |
// |            DATA_W       data width (bit write enable width too)          |
// |            STARVE_LIMIT consecutive IF refusals before IF wins one       |
// |                         contested cycle (1..15)                          |
// | Config   : SRAM_ARB_RR_EN defined  -> contested cycles alternate; the    |
// |                                      loser of the last contest wins.     |
// |            SRAM_ARB_RR_EN undefined -> DM fixed priority with an IF      |
// |                                      starvation guard.                   |
// | Revision : 1.0  initial release                                          |
// ============================================================================
module sram_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input wire                 clk,
  input wire                 rst_n,
  sram_port_arbiter_if.slave bus
);

  localparam logic [DATA_W-1:0] c_all_ones = '1;

  // Which port's read is in flight to the SRAM output register.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } rd_owner_e;

  logic              w_contested;
  logic              w_if_gnt;
  logic              w_dm_gnt;

  rd_owner_e         rd_owner_q;
  rd_owner_e         rd_owner_d;

  logic              w_if_rvalid;
  logic              w_dm_rvalid;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q;
  logic [DATA_W-1:0] dm_rdata_d;

  logic              w_sram_ceb;
  logic              w_sram_web;
  logic [DATA_W-1:0] w_sram_bweb;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [ADDR_W-1:0] sram_addr_d;
  logic [DATA_W-1:0] sram_din_q;
  logic [DATA_W-1:0] sram_din_d;

  assign w_contested = bus.if_req & bus.dm_req;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef SRAM_ARB_RR_EN
  localparam logic c_win_if = 1'b0;
  localparam logic c_win_dm = 1'b1;

  // Winner of the most recent contested cycle. Resets to IF so that the
  // first contest after reset goes to DM.
  logic last_win_q;
  logic last_win_d;

  always_comb begin
    w_if_gnt = bus.if_req;
    w_dm_gnt = bus.dm_req;
    if (w_contested) begin
      w_if_gnt = (last_win_q == c_win_dm);
      w_dm_gnt = ~w_if_gnt;
    end
  end

  // Only contested cycles move the turn; uncontested grants leave it alone.
  always_comb begin
    last_win_d = last_win_q;
    if (w_contested) begin
      last_win_d = w_dm_gnt ? c_win_dm : c_win_if;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win_q <= c_win_if;
    end else begin
      last_win_q <= last_win_d;
    end
  end
`else
  localparam logic [3:0] c_starve_lim = 4'(STARVE_LIMIT);

  // Consecutive cycles in which a pending fetch was refused.
  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  // DM has priority; once IF has been refused c_starve_lim times in a row
  // it takes the next contested cycle.
  always_comb begin
    w_if_gnt = bus.if_req;
    w_dm_gnt = bus.dm_req;
    if (w_contested) begin
      w_if_gnt = (starve_cnt_q == c_starve_lim);
      w_dm_gnt = ~w_if_gnt;
    end
  end

  // Counts refusals only; any grant or an idle fetch port restarts it.
  always_comb begin
    starve_cnt_d = '0;
    if (bus.if_req && !w_if_gnt) begin
      starve_cnt_d = (starve_cnt_q >= c_starve_lim) ? c_starve_lim
                                                     : starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // SRAM drive
  // --------------------------------------------------------------------------
  // Address and write data are don't-care when idle; holding the last driven
  // value avoids needless toggling on the macro pins.
  always_comb begin
    w_sram_ceb  = 1'b1;
    w_sram_web  = 1'b1;
    w_sram_bweb = c_all_ones;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    if (w_if_gnt) begin
      w_sram_ceb  = 1'b0;
      sram_addr_d = bus.if_addr;
    end else if (w_dm_gnt) begin
      w_sram_ceb  = 1'b0;
      w_sram_web  = ~bus.dm_we;
      w_sram_bweb = bus.dm_we ? bus.dm_bweb : c_all_ones;
      sram_addr_d = bus.dm_addr;
      sram_din_d  = bus.dm_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read ownership FSM
  // --------------------------------------------------------------------------
  // The owner for the next cycle is whichever port has a read granted now;
  // DM writes and idle cycles leave nothing in flight.
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (w_if_gnt) begin
      rd_owner_d = OWN_IF;
    end else if (w_dm_gnt && !bus.dm_we) begin
      rd_owner_d = OWN_DM;
    end
  end

  // --------------------------------------------------------------------------
  // Read response
  // --------------------------------------------------------------------------
  // sram_dout is itself registered by the macro, so during the response
  // cycle it is passed straight to the owning port and captured at the end
  // of that cycle; afterwards the captured copy is presented until the port's
  // next response. The non-owning port keeps showing its captured value.
  assign w_if_rvalid = (rd_owner_q == OWN_IF);
  assign w_dm_rvalid = (rd_owner_q == OWN_DM);

  always_comb begin
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if (w_if_rvalid) begin
      if_rdata_d = bus.sram_dout;
    end
    if (w_dm_rvalid) begin
      dm_rdata_d = bus.sram_dout;
    end
  end

  // An asynchronous reset clears rd_owner_q, which drops any response that
  // was still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q  <= OWN_NONE;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.if_gnt    = w_if_gnt;
  assign bus.dm_gnt    = w_dm_gnt;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.dm_rvalid = w_dm_rvalid;
  assign bus.if_rdata  = if_rdata_d;
  assign bus.dm_rdata  = dm_rdata_d;
  assign bus.sram_ceb  = w_sram_ceb;
  assign bus.sram_web  = w_sram_web;
  assign bus.sram_bweb = w_sram_bweb;
  assign bus.sram_addr = sram_addr_d;
  assign bus.sram_din  = sram_din_d;
  assign bus.cpu_stall = (bus.if_req & ~w_if_gnt) | (bus.dm_req & ~w_dm_gnt);

endmodule : sram_port_arbiter
`default_nettype wire
